// File: rtl/spi_master.sv
// Mode-0 SPI initiator: shifts {adr, data_wr} out MSB first while capturing
// DATASIZE bits of read data from miso, with a cs-high guard gap after each frame.
module spi_master #(
  parameter int ADRSIZE  = 8,
  parameter int DATASIZE = 32,
  parameter int CLK_DIV  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADRSIZE-1:0]  adr,
  input  logic [DATASIZE-1:0] data_wr,
  output logic [DATASIZE-1:0] data_rd,
  output logic                busy,
  output logic                done,
  output logic                sclk,
  output logic                cs,
  output logic                mosi,
  input  logic                miso
);

  localparam int N  = ADRSIZE + DATASIZE;
  localparam int EW = $clog2(N + 1);

  localparam logic [7:0]    H_LAST = 8'(CLK_DIV - 1);
  localparam logic [EW-1:0] E_LAST = EW'(N);
  localparam logic [EW-1:0] E_ADR  = EW'(ADRSIZE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_hcnt, w_hcnt_nxt;
  logic [EW-1:0]       r_ecnt, w_ecnt_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_cs, w_cs_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic [DATASIZE-1:0] r_data_rd, w_data_rd_nxt;
  logic [N-1:0]        r_tx, w_tx_nxt;
  logic [DATASIZE-1:0] r_rx, w_rx_nxt;
  logic                w_hlast;

  assign w_hlast = (r_hcnt == H_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_hcnt_nxt    = w_hlast ? 8'd0 : r_hcnt + 8'd1;
    w_ecnt_nxt    = r_ecnt;
    w_sclk_nxt    = r_sclk;
    w_cs_nxt      = r_cs;
    w_mosi_nxt    = r_mosi;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_data_rd_nxt = r_data_rd;
    w_tx_nxt      = r_tx;
    w_rx_nxt      = r_rx;

    case (r_state)
      IDLE: begin
        w_hcnt_nxt = 8'd0;
        if (start) begin
          w_tx_nxt    = {adr, data_wr};
          w_mosi_nxt  = adr[ADRSIZE-1];
          w_cs_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_ecnt_nxt  = '0;
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        // First rising edge; its miso bit belongs to the address phase and is dropped.
        if (w_hlast) begin
          w_sclk_nxt  = 1'b1;
          w_ecnt_nxt  = EW'(1);
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_hlast) begin
          if (r_sclk) begin
            w_sclk_nxt = 1'b0;
            if (r_ecnt == E_LAST) begin
              w_mosi_nxt  = 1'b0;
              w_state_nxt = HOLD;
            end else begin
              w_mosi_nxt = r_tx[N-2];
              w_tx_nxt   = r_tx << 1;
            end
          end else begin
            w_sclk_nxt = 1'b1;
            w_ecnt_nxt = r_ecnt + 1'b1;
            // Data-phase bits arrive LSB first, so shift in from the top.
            if (r_ecnt >= E_ADR) begin
              w_rx_nxt = {miso, r_rx[DATASIZE-1:1]};
            end
          end
        end
      end
      HOLD: begin
        if (w_hlast) begin
          w_cs_nxt      = 1'b1;
          w_done_nxt    = 1'b1;
          w_data_rd_nxt = r_rx;
          w_state_nxt   = GAP;
        end
      end
      GAP: begin
        if (w_hlast) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_hcnt    <= 8'd0;
      r_ecnt    <= '0;
      r_sclk    <= 1'b0;
      r_cs      <= 1'b1;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_data_rd <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_ecnt    <= w_ecnt_nxt;
      r_sclk    <= w_sclk_nxt;
      r_cs      <= w_cs_nxt;
      r_mosi    <= w_mosi_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_data_rd <= w_data_rd_nxt;
    end
  end

  // Shift registers are fully reloaded every frame, so they carry no reset.
  always_ff @(posedge clock) begin
    r_tx <= w_tx_nxt;
    r_rx <= w_rx_nxt;
  end

  assign data_rd = r_data_rd;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sclk    = r_sclk;
  assign cs      = r_cs;
  assign mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four instances (H = 2, 4, 3, 1), a timeline model of
// each frame checked every cycle, a bench SPI slave, and directed frame checks.
module tb_spi_master;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        chk_en  = 1'b0;

  logic        start_s [4];
  logic [7:0]  adr_s   [4];
  logic [31:0] dwr_s   [4];
  logic [31:0] drd_s   [4];
  logic        busy_s  [4];
  logic        done_s  [4];
  logic        sclk_s  [4];
  logic        cs_s    [4];
  logic        mosi_s  [4];
  logic        miso_s  [4] = '{default: 1'b0};
  logic [31:0] pat     [4];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_master #(
      .ADRSIZE (8),
      .DATASIZE(32),
      .CLK_DIV ((g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 3 : 1)
    ) u_dut (
      .clock  (clock),
      .reset_n(reset_n),
      .start  (start_s[g]),
      .adr    (adr_s[g]),
      .data_wr(dwr_s[g]),
      .data_rd(drd_s[g]),
      .busy   (busy_s[g]),
      .done   (done_s[g]),
      .sclk   (sclk_s[g]),
      .cs     (cs_s[g]),
      .mosi   (mosi_s[g]),
      .miso   (miso_s[g])
    );
  end

  function automatic int hv(int i);
    return (i == 0) ? 2 : (i == 1) ? 4 : (i == 2) ? 3 : 1;
  endfunction

  // Frame model: acceptance cycle t0 plus the timeline of the frame relative to it.
  bit          m_act [4] = '{default: 1'b0};
  int          m_t0  [4] = '{default: 0};
  logic [39:0] m_bits[4] = '{default: 40'd0};
  logic [31:0] m_pat [4] = '{default: 32'd0};
  logic [31:0] m_rd  [4] = '{default: 32'd0};

  always @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n) begin
        m_act[i] = 1'b0;
        m_rd[i]  = 32'd0;
      end else begin
        if (m_act[i] && (cyc - m_t0[i] >= 82 * hv(i) + 1)) m_act[i] = 1'b0;
        if (!m_act[i] && start_s[i]) begin
          m_act[i]  = 1'b1;
          m_t0[i]   = cyc;
          m_bits[i] = {adr_s[i], dwr_s[i]};
          m_pat[i]  = pat[i];
        end
      end
    end
    cyc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (reset_n && m_act[i] && (cyc - m_t0[i] == 81 * hv(i) + 1)) m_rd[i] = m_pat[i];
    end
  end

  // Expected {busy, done, sclk, cs, mosi} for the current cycle.
  function automatic logic [4:0] exp_out(int i);
    int   c, h;
    logic b, d, s, csn, m;
    h = hv(i);
    c = cyc - m_t0[i];
    if (!reset_n || !m_act[i]) return 5'b00010;
    b   = (c >= 1) && (c <= 82 * h);
    d   = (c == 81 * h + 1);
    csn = !((c >= 1) && (c <= 81 * h));
    s   = (c >= 1) && (c - 1 < 80 * h) && (((c - 1) / h) % 2 == 1);
    m   = 1'b0;
    if ((c >= 1) && (c <= 80 * h)) m = m_bits[i][39 - (c - 1) / (2 * h)];
    return {b, d, s, csn, m};
  endfunction

  // Bench slave: records mosi on rising sclk, drives pat LSB first after falling edges 8..39.
  int          rise_cnt   [4] = '{default: 0};
  int          fall_cnt   [4] = '{default: 0};
  int          ncap       [4] = '{default: 0};
  int          nfall      [4] = '{default: 0};
  int          done_cnt   [4] = '{default: 0};
  int          cs_rise_cyc[4] = '{default: 0};
  logic [39:0] mcap       [4] = '{default: 40'd0};
  logic        p_sclk     [4] = '{default: 1'b0};
  logic        p_cs       [4] = '{default: 1'b1};
  logic [39:0] cap_log [4][16];
  int          rise_log[4][16];
  int          gap_log [4][16];

  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (p_cs[i] && !cs_s[i]) begin
        rise_cnt[i] = 0;
        fall_cnt[i] = 0;
        mcap[i]     = 40'd0;
        miso_s[i]   = pat[i][0];
        gap_log[i][nfall[i] % 16] = cyc - cs_rise_cyc[i];
        nfall[i]    = nfall[i] + 1;
      end
      if (!p_cs[i] && cs_s[i]) begin
        cap_log[i][ncap[i] % 16]  = mcap[i];
        rise_log[i][ncap[i] % 16] = rise_cnt[i];
        ncap[i]        = ncap[i] + 1;
        cs_rise_cyc[i] = cyc;
      end
      if (!cs_s[i] && sclk_s[i] && !p_sclk[i]) begin
        mcap[i]     = {mcap[i][38:0], mosi_s[i]};
        rise_cnt[i] = rise_cnt[i] + 1;
      end
      if (!cs_s[i] && !sclk_s[i] && p_sclk[i]) begin
        fall_cnt[i] = fall_cnt[i] + 1;
        if (fall_cnt[i] >= 8 && fall_cnt[i] <= 39) miso_s[i] = pat[i][fall_cnt[i] - 8];
      end
      if (done_s[i]) done_cnt[i] = done_cnt[i] + 1;
      p_sclk[i] = sclk_s[i];
      p_cs[i]   = cs_s[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic launch(input int i, input logic [7:0] a, input logic [31:0] d, output int t0);
    adr_s[i]   = a;
    dwr_s[i]   = d;
    start_s[i] = 1'b1;
    t0 = cyc;
    tick();
    start_s[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim, output int td);
    td = -1;
    for (int k = 0; k < lim; k++) begin
      if (done_s[i]) begin
        td = cyc;
        break;
      end
      tick();
    end
    if (td < 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL timeout waiting for done on instance %0d", i);
    end
  endtask

  task automatic wait_idle(input int i, input int lim, output int ti);
    ti = -1;
    for (int k = 0; k < lim; k++) begin
      if (!busy_s[i]) begin
        ti = cyc;
        break;
      end
      tick();
    end
    if (ti < 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL timeout waiting for busy low on instance %0d", i);
    end
  endtask

  function automatic logic [39:0] last_cap(int i);
    return cap_log[i][(ncap[i] + 15) % 16];
  endfunction

  function automatic int last_rise(int i);
    return rise_log[i][(ncap[i] + 15) % 16];
  endfunction

  logic [7:0]  va[3] = '{8'h11, 8'h22, 8'h33};
  logic [31:0] vd[3] = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98};

  initial begin
    int t0, td, ti, d0, f0, c0, nf;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      adr_s[i]   = 8'd0;
      dwr_s[i]   = 32'd0;
      pat[i]     = 32'd0;
    end
    reset_n = 1'b0;

    fork
      begin
        logic [4:0]  e, g;
        logic [31:0] erd;
        forever begin
          @(negedge clock);
          if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
              e = exp_out(i);
              g = {busy_s[i], done_s[i], sclk_s[i], cs_s[i], mosi_s[i]};
              n_assert++;
              if (g !== e) begin
                n_fail++;
                $display("FAIL outs[%0d] cyc=%0d busy,done,sclk,cs,mosi got %b expected %b", i, cyc, g, e);
              end
              erd = reset_n ? m_rd[i] : 32'd0;
              n_assert++;
              if (drd_s[i] !== erd) begin
                n_fail++;
                $display("FAIL data_rd[%0d] cyc=%0d got %h expected %h", i, cyc, drd_s[i], erd);
              end
            end
          end
        end
      end
    join_none

    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      chk("reset_outs", 64'({busy_s[i], done_s[i], sclk_s[i], cs_s[i], mosi_s[i]}), 64'(5'b00010));
      chk("reset_data_rd", 64'(drd_s[i]), 64'd0);
    end
    chk_en  = 1'b1;
    reset_n = 1'b1;
    repeat (2) tick();

    // Write frame, H=2
    pat[0] = 32'hA5A5F00F;
    launch(0, 8'h5A, 32'hDEADBEEF, t0);
    wait_done(0, 400, td);
    chk("t1_done_time", 64'(td - t0), 64'd163);
    chk("t1_rise_edges", 64'(last_rise(0)), 64'd40);
    chk("t1_mosi_stream", 64'(last_cap(0)), 64'h5ADEADBEEF);
    chk("t1_data_rd", 64'(drd_s[0]), 64'hA5A5F00F);
    wait_idle(0, 20, ti);
    chk("t1_busy_low_time", 64'(ti - t0), 64'd165);
    repeat (3) tick();

    // Read frame, H=4
    pat[1] = 32'h12345678;
    launch(1, 8'h81, 32'h00000000, t0);
    wait_done(1, 700, td);
    chk("t2_done_time", 64'(td - t0), 64'd325);
    chk("t2_data_rd_done", 64'(drd_s[1]), 64'h12345678);
    repeat (10) tick();
    chk("t2_data_rd_held", 64'(drd_s[1]), 64'h12345678);
    wait_idle(1, 20, ti);
    repeat (3) tick();

    // Start while busy is ignored
    d0 = done_cnt[1];
    f0 = nfall[1];
    pat[1] = 32'h600DCAFE;
    launch(1, 8'h3C, 32'h55AA55AA, t0);
    repeat (9) tick();
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    wait_idle(1, 700, ti);
    repeat (5) tick();
    chk("t3_done_pulses", 64'(done_cnt[1] - d0), 64'd1);
    chk("t3_cs_low_periods", 64'(nfall[1] - f0), 64'd1);
    chk("t3_mosi_stream", 64'(last_cap(1)), 64'h3C55AA55AA);
    chk("t3_data_rd", 64'(drd_s[1]), 64'h600DCAFE);

    // start held high for three back-to-back frames, H=3
    d0 = done_cnt[2];
    f0 = nfall[2];
    c0 = ncap[2];
    pat[2]     = 32'hC0FFEE00;
    adr_s[2]   = va[0];
    dwr_s[2]   = vd[0];
    start_s[2] = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      tick();
      nf = nfall[2] - f0;
      if (nf >= 1 && nf <= 2) begin
        adr_s[2] = va[nf];
        dwr_s[2] = vd[nf];
      end
      if (done_cnt[2] - d0 >= 3) break;
    end
    start_s[2] = 1'b0;
    wait_idle(2, 50, ti);
    repeat (10) tick();
    chk("t4_done_pulses", 64'(done_cnt[2] - d0), 64'd3);
    chk("t4_cs_low_periods", 64'(nfall[2] - f0), 64'd3);
    chk("t4_gap1_ge_h", 64'(gap_log[2][(f0 + 1) % 16] >= 3), 64'd1);
    chk("t4_gap2_ge_h", 64'(gap_log[2][(f0 + 2) % 16] >= 3), 64'd1);
    for (int j = 0; j < 3; j++) begin
      chk("t4_frame_mosi", 64'(cap_log[2][(c0 + j) % 16]), 64'({va[j], vd[j]}));
    end
    chk("t4_data_rd", 64'(drd_s[2]), 64'hC0FFEE00);

    // Reset mid-frame after rising edge 20, then a clean frame
    pat[0] = 32'h0BADF00D;
    launch(0, 8'hC3, 32'h0F0F1234, t0);
    td = -1;
    for (int k = 0; k < 200; k++) begin
      if (rise_cnt[0] == 20) begin
        td = cyc;
        break;
      end
      tick();
    end
    if (td < 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL timeout waiting for rising edge 20");
    end
    d0 = done_cnt[0];
    reset_n = 1'b0;
    #1;
    chk("t5_reset_outs", 64'({busy_s[0], done_s[0], sclk_s[0], cs_s[0], mosi_s[0]}), 64'(5'b00010));
    chk("t5_reset_data_rd", 64'(drd_s[0]), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t5_no_done", 64'(done_cnt[0] - d0), 64'd0);
    launch(0, 8'h96, 32'h13579BDF, t0);
    wait_done(0, 400, td);
    chk("t5_done_time", 64'(td - t0), 64'd163);
    chk("t5_mosi_stream", 64'(last_cap(0)), 64'h9613579BDF);
    chk("t5_data_rd", 64'(drd_s[0]), 64'h0BADF00D);
    wait_idle(0, 20, ti);
    repeat (3) tick();

    // H=1 boundary, miso held high
    pat[3] = 32'hFFFFFFFF;
    launch(3, 8'hFF, 32'h00000001, t0);
    wait_done(3, 200, td);
    chk("t6_done_time", 64'(td - t0), 64'd82);
    chk("t6_rise_edges", 64'(last_rise(3)), 64'd40);
    chk("t6_mosi_stream", 64'(last_cap(3)), 64'hFF00000001);
    chk("t6_data_rd", 64'(drd_s[3]), 64'hFFFFFFFF);
    wait_idle(3, 20, ti);
    chk("t6_busy_low_time", 64'(ti - t0), 64'd83);
    repeat (3) tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
